// File: rtl/connect4_game_ctrl.sv
// connect4_game_ctrl: move sequencer for a 6x7 Connect 4 board.
// Clears the board RAM after reset, turns one-cycle move requests into a
// board write at the lowest free row, launches the external win checker and
// keeps turn, winner and draw state.
// Optional feature: define TURN_TIMEOUT_EN to enable an idle-turn auto-move
// after TIMEOUT_CYCLES cycles in WAIT.
// The board write port and chk_start are registered: the first CLEAR cycle
// after reset fills that register, so the 42 clearing writes appear on the
// following 42 cycles and busy only drops once the last one has been issued.
module connect4_game_ctrl #(
   parameter int ROWS = 6,
   parameter int COLS = 7
`ifdef TURN_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
   input  logic       clk,
   input  logic       KEY0,
   input  logic       play_req,
   input  logic [2:0] col_sel,
   output logic       wr_en,
   output logic [2:0] wr_row,
   output logic [2:0] wr_col,
   output logic [1:0] wr_player,
   output logic       chk_start,
   output logic [2:0] chk_row,
   output logic [2:0] chk_col,
   input  logic       chk_done,
   input  logic       chk_win,
   output logic [1:0] jugador_actual,
   output logic       hay_ganador,
   output logic       empate,
   output logic       move_invalid,
   output logic       busy
);

   localparam logic [2:0] ROWS_L  = 3'(ROWS);
   localparam logic [2:0] COLS_L  = 3'(COLS);
   localparam logic [5:0] CELLS_L = 6'(ROWS * COLS);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_WAIT,
      S_WRITE,
      S_CHECK,
      S_WIN,
      S_DRAW
   } state_t;

   logic rst_n;
   assign rst_n = KEY0;

   state_t     state_q, state_d;
   logic [1:0] player_q, player_d;
   logic       win_q, win_d;
   logic       draw_q, draw_d;
   logic       invalid_q, invalid_d;
   logic [2:0] height_q [COLS];
   logic [2:0] height_d [COLS];
   logic [5:0] move_cnt_q, move_cnt_d;
   logic [2:0] cur_row_q, cur_row_d;
   logic [2:0] cur_col_q, cur_col_d;
   logic [5:0] clr_idx_q, clr_idx_d;
   logic [2:0] clr_row_q, clr_row_d;
   logic [2:0] clr_col_q, clr_col_d;
   logic       wr_en_q, wr_en_d;
   logic [2:0] wr_row_q, wr_row_d;
   logic [2:0] wr_col_q, wr_col_d;
   logic [1:0] wr_player_q, wr_player_d;
   logic       chk_start_q, chk_start_d;

   logic [2:0] sel_height;
   logic       sel_ok;

   logic       timeout_hit;
   logic [2:0] auto_col;
   logic [2:0] auto_row;

   // Look up the height of the requested column and decide if the drop fits
   always_comb begin
      sel_height = '0;
      for (int c = 0; c < COLS; c++) begin
         if (col_sel == 3'(c)) begin
            sel_height = height_q[c];
         end
      end
      sel_ok = (col_sel < COLS_L) && (sel_height < ROWS_L);
   end

`ifdef TURN_TIMEOUT_EN
   logic [31:0] idle_q, idle_d;
   logic        auto_ok;

   // Pick the lowest-index column that still has room for the auto-move
   always_comb begin
      auto_ok  = 1'b0;
      auto_col = '0;
      auto_row = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (height_q[c] < ROWS_L) begin
            auto_ok  = 1'b1;
            auto_col = 3'(c);
            auto_row = height_q[c];
         end
      end
   end

   assign timeout_hit = (state_q == S_WAIT) && !play_req && auto_ok &&
                        (idle_q == 32'(TIMEOUT_CYCLES - 1));

   // Idle counter only runs while waiting quietly; any request or leaving WAIT restarts it
   always_comb begin
      idle_d = '0;
      if ((state_q == S_WAIT) && !play_req && !timeout_hit) begin
         idle_d = idle_q + 32'd1;
      end
   end

   // Idle counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign auto_col    = '0;
   assign auto_row    = '0;
`endif

   // Next-state, board bookkeeping and registered-output computation
   always_comb begin
      state_d     = state_q;
      player_d    = player_q;
      win_d       = win_q;
      draw_d      = draw_q;
      invalid_d   = 1'b0;
      height_d    = height_q;
      move_cnt_d  = move_cnt_q;
      cur_row_d   = cur_row_q;
      cur_col_d   = cur_col_q;
      clr_idx_d   = clr_idx_q;
      clr_row_d   = clr_row_q;
      clr_col_d   = clr_col_q;
      wr_en_d     = 1'b0;
      wr_row_d    = wr_row_q;
      wr_col_d    = wr_col_q;
      wr_player_d = wr_player_q;
      chk_start_d = 1'b0;

      case (state_q)
         S_CLEAR: begin
            if (clr_idx_q < CELLS_L) begin
               wr_en_d     = 1'b1;
               wr_row_d    = clr_row_q;
               wr_col_d    = clr_col_q;
               wr_player_d = 2'd0;
               clr_idx_d   = clr_idx_q + 6'd1;
               if (clr_col_q == COLS_L - 3'd1) begin
                  clr_col_d = '0;
                  clr_row_d = clr_row_q + 3'd1;
               end else begin
                  clr_col_d = clr_col_q + 3'd1;
               end
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (play_req) begin
               if (sel_ok) begin
                  cur_row_d   = sel_height;
                  cur_col_d   = col_sel;
                  wr_en_d     = 1'b1;
                  wr_row_d    = sel_height;
                  wr_col_d    = col_sel;
                  wr_player_d = player_q;
                  state_d     = S_WRITE;
               end else begin
                  invalid_d = 1'b1;
               end
            end else if (timeout_hit) begin
               cur_row_d   = auto_row;
               cur_col_d   = auto_col;
               wr_en_d     = 1'b1;
               wr_row_d    = auto_row;
               wr_col_d    = auto_col;
               wr_player_d = player_q;
               state_d     = S_WRITE;
            end
         end

         S_WRITE: begin
            for (int c = 0; c < COLS; c++) begin
               if ((cur_col_q == 3'(c)) && (height_q[c] < ROWS_L)) begin
                  height_d[c] = height_q[c] + 3'd1;
               end
            end
            move_cnt_d  = move_cnt_q + 6'd1;
            chk_start_d = 1'b1;
            state_d     = S_CHECK;
         end

         S_CHECK: begin
            if (chk_done) begin
               if (chk_win) begin
                  win_d   = 1'b1;
                  state_d = S_WIN;
               end else if (move_cnt_q == CELLS_L) begin
                  draw_d  = 1'b1;
                  state_d = S_DRAW;
               end else begin
                  player_d = (player_q == 2'd1) ? 2'd2 : 2'd1;
                  state_d  = S_WAIT;
               end
            end
         end

         S_WIN:   state_d = S_WIN;
         S_DRAW:  state_d = S_DRAW;
         default: state_d = S_CLEAR;
      endcase
   end

   // State and datapath registers; reset restarts the board clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_CLEAR;
         player_q    <= 2'd1;
         win_q       <= 1'b0;
         draw_q      <= 1'b0;
         invalid_q   <= 1'b0;
         for (int c = 0; c < COLS; c++) begin
            height_q[c] <= '0;
         end
         move_cnt_q  <= '0;
         cur_row_q   <= '0;
         cur_col_q   <= '0;
         clr_idx_q   <= '0;
         clr_row_q   <= '0;
         clr_col_q   <= '0;
         wr_en_q     <= 1'b0;
         wr_row_q    <= '0;
         wr_col_q    <= '0;
         wr_player_q <= '0;
         chk_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         player_q    <= player_d;
         win_q       <= win_d;
         draw_q      <= draw_d;
         invalid_q   <= invalid_d;
         height_q    <= height_d;
         move_cnt_q  <= move_cnt_d;
         cur_row_q   <= cur_row_d;
         cur_col_q   <= cur_col_d;
         clr_idx_q   <= clr_idx_d;
         clr_row_q   <= clr_row_d;
         clr_col_q   <= clr_col_d;
         wr_en_q     <= wr_en_d;
         wr_row_q    <= wr_row_d;
         wr_col_q    <= wr_col_d;
         wr_player_q <= wr_player_d;
         chk_start_q <= chk_start_d;
      end
   end

   assign wr_en          = wr_en_q;
   assign wr_row         = wr_row_q;
   assign wr_col         = wr_col_q;
   assign wr_player      = wr_player_q;
   assign chk_start      = chk_start_q;
   assign chk_row        = cur_row_q;
   assign chk_col        = cur_col_q;
   assign jugador_actual = player_q;
   assign hay_ganador    = win_q;
   assign empate         = draw_q;
   assign move_invalid   = invalid_q;
   assign busy           = (state_q != S_WAIT);

endmodule
